// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: multiplexed hex 7-segment scanner with frame-latched inputs, leading-zero blanking and PWM brightness
module sseg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   sw,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            sseg,
  output logic                  dp,
  output logic                  frame_tick
);
  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int K  = REFRESH_DIV / 16;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [TW-1:0]       tick;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] s_sw, e_sw;
  logic [DIGITS-1:0]   s_dp, e_dp;
  logic                s_blz, e_blz;
  logic [3:0]          s_br, e_br, nib;
  logic                frame, blank, lit;
  // In the frame-start cycle the shadows are being loaded, so the live inputs are used directly
  always_comb begin
    frame = tick == '0 && idx == '0;
    e_sw  = frame ? sw : s_sw;
    e_dp  = frame ? dp_in : s_dp;
    e_blz = frame ? blank_lz : s_blz;
    e_br  = frame ? bright : s_br;
    nib   = e_sw[4*idx +: 4];
    blank = e_blz && idx != '0 && (e_sw >> (4*idx)) == '0;
    lit   = !blank && (32'(tick) < (32'(e_br) + 1) * K);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick       <= '0;
      idx        <= '0;
      s_sw       <= '0;
      s_dp       <= '0;
      s_blz      <= 1'b0;
      s_br       <= '0;
      an         <= '1;
      sseg       <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      tick <= tick == TW'(REFRESH_DIV - 1) ? '0 : tick + 1'b1;
      if (tick == TW'(REFRESH_DIV - 1))
        idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      if (frame) begin
        s_sw  <= sw;
        s_dp  <= dp_in;
        s_blz <= blank_lz;
        s_br  <= bright;
      end
      an         <= lit ? ~(DIGITS'(1) << idx) : '1;
      sseg       <= lit ? HEX[nib] : 7'h7F;
      dp         <= lit ? ~e_dp[idx] : 1'b1;
      frame_tick <= frame;
    end
  end
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: table vectors, corner sequences and randomized model check of sseg_scan_mux
module tb_sseg_scan_mux;
  logic        clk = 0, reset = 0, blank_lz = 0, dp, frame_tick;
  logic [15:0] sw = 0;
  logic [3:0]  dp_in = 0, bright = 0, an;
  logic [6:0]  sseg;
  int n_chk = 0, n_fail = 0, p = 0;
  logic [15:0] m_sw;
  logic [3:0]  m_dp, m_br, e_an;
  logic        m_blz, e_dp, e_ft;
  logic [6:0]  e_sg;
  logic [6:0]  hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct {
    logic [15:0] sw; logic [3:0] dpi; logic blz; logic [3:0] br; int pos;
    logic [3:0] an; logic [6:0] sg; logic dp; logic ft;
  } vec_t;
  vec_t v [17];
  sseg_scan_mux #(.DIGITS(4), .REFRESH_DIV(16)) dut (
    .clk(clk), .reset(reset), .sw(sw), .dp_in(dp_in), .blank_lz(blank_lz), .bright(bright),
    .an(an), .sseg(sseg), .dp(dp), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    int d, t;
    logic blank, lit;
    @(posedge clk);
    if (!reset) begin
      p = 0; m_sw = 0; m_dp = 0; m_blz = 0; m_br = 0;
      e_an = 4'hF; e_sg = 7'h7F; e_dp = 1; e_ft = 0;
    end else begin
      if (p == 0) begin m_sw = sw; m_dp = dp_in; m_blz = blank_lz; m_br = bright; end
      d = p / 16; t = p % 16;
      blank = m_blz && d != 0 && (m_sw >> (4*d)) == 0;
      lit = !blank && t < int'(m_br) + 1;
      e_an = lit ? ~(4'b1 << d) : 4'hF;
      e_sg = lit ? hex[(m_sw >> (4*d)) & 16'hF] : 7'h7F;
      e_dp = lit ? ~m_dp[d] : 1'b1;
      e_ft = p == 0;
      p = (p + 1) % 64;
    end
    #1;
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_sseg", 32'(sseg), 32'(e_sg));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_ft", 32'(frame_tick), 32'(e_ft));
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  initial begin
    v[0]  = '{16'h1234, 4'h0, 1'b0, 4'hF, 0,  4'hE, 7'h19, 1'b1, 1'b1};
    v[1]  = '{16'h1234, 4'h0, 1'b0, 4'hF, 16, 4'hD, 7'h30, 1'b1, 1'b0};
    v[2]  = '{16'h1234, 4'h0, 1'b0, 4'hF, 32, 4'hB, 7'h24, 1'b1, 1'b0};
    v[3]  = '{16'h1234, 4'h0, 1'b0, 4'hF, 48, 4'h7, 7'h79, 1'b1, 1'b0};
    v[4]  = '{16'hABCD, 4'h0, 1'b0, 4'hF, 0,  4'hE, 7'h21, 1'b1, 1'b1};
    v[5]  = '{16'hABCD, 4'h0, 1'b0, 4'hF, 48, 4'h7, 7'h08, 1'b1, 1'b0};
    v[6]  = '{16'h0000, 4'h0, 1'b1, 4'hF, 0,  4'hE, 7'h40, 1'b1, 1'b1};
    v[7]  = '{16'h0000, 4'h0, 1'b1, 4'hF, 16, 4'hF, 7'h7F, 1'b1, 1'b0};
    v[8]  = '{16'h0050, 4'h0, 1'b1, 4'hF, 16, 4'hD, 7'h12, 1'b1, 1'b0};
    v[9]  = '{16'h0050, 4'h0, 1'b1, 4'hF, 32, 4'hF, 7'h7F, 1'b1, 1'b0};
    v[10] = '{16'h1234, 4'h0, 1'b0, 4'h0, 16, 4'hD, 7'h30, 1'b1, 1'b0};
    v[11] = '{16'h1234, 4'h0, 1'b0, 4'h0, 17, 4'hF, 7'h7F, 1'b1, 1'b0};
    v[12] = '{16'h1234, 4'h0, 1'b0, 4'h7, 7,  4'hE, 7'h19, 1'b1, 1'b0};
    v[13] = '{16'h1234, 4'h0, 1'b0, 4'h7, 8,  4'hF, 7'h7F, 1'b1, 1'b0};
    v[14] = '{16'h1234, 4'h4, 1'b0, 4'hF, 32, 4'hB, 7'h24, 1'b0, 1'b0};
    v[15] = '{16'h1234, 4'h4, 1'b0, 4'hF, 16, 4'hD, 7'h30, 1'b1, 1'b0};
    v[16] = '{16'h0000, 4'h0, 1'b0, 4'hF, 48, 4'h7, 7'h40, 1'b1, 1'b0};
    run(2);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_sseg", 32'(sseg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_ft", 32'(frame_tick), 32'h0);
    for (int i = 0; i < 17; i++) begin
      reset = 0;
      run(2);
      sw = v[i].sw; dp_in = v[i].dpi; blank_lz = v[i].blz; bright = v[i].br;
      reset = 1;
      run(v[i].pos + 1);
      chk($sformatf("vec%0d_an", i), 32'(an), 32'(v[i].an));
      chk($sformatf("vec%0d_sseg", i), 32'(sseg), 32'(v[i].sg));
      chk($sformatf("vec%0d_dp", i), 32'(dp), 32'(v[i].dp));
      chk($sformatf("vec%0d_ft", i), 32'(frame_tick), 32'(v[i].ft));
    end
    reset = 0; run(2);
    sw = 16'h1234; dp_in = 0; blank_lz = 0; bright = 15; reset = 1;
    run(21);
    sw = 16'hABCD;
    run(28);
    chk("tear_d3_same_frame", 32'(sseg), 32'h79);
    run(16);
    chk("tear_d0_next_frame", 32'(sseg), 32'h21);
    chk("tear_ft_next_frame", 32'(frame_tick), 32'h1);
    run(40);
    reset = 0; run(1);
    chk("midreset_an", 32'(an), 32'hF);
    chk("midreset_sseg", 32'(sseg), 32'h7F);
    reset = 1; run(1);
    chk("restart_an", 32'(an), 32'hE);
    chk("restart_ft", 32'(frame_tick), 32'h1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        sw = 16'($urandom) & {{4{$urandom_range(0, 1) == 1'b1}}, {4{$urandom_range(0, 1) == 1'b1}},
                              {4{$urandom_range(0, 1) == 1'b1}}, 4'hF};
        dp_in = 4'($urandom);
        blank_lz = 1'($urandom);
        bright = 4'($urandom);
      end
      reset = $urandom_range(0, 299) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
